// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT word, power and state types for the spectral stages
package fft_pkg;
    localparam int FFT_ADDR_W = 10;
    localparam int PWR_W      = 28;

    typedef struct packed {
        logic signed [13:0] re;
        logic signed [13:0] im;
    } fft_word_t;

    typedef logic [PWR_W-1:0] pwr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_FINISH
    } pd_state_t;
endpackage

// File: rtl/mag_sq.sv
// rtl/mag_sq.sv - registered |X|^2 of one FFT word with valid/tag passthrough
module mag_sq
    import fft_pkg::*;
#(
    parameter int TAG_W = FFT_ADDR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    input  logic [TAG_W-1:0] i_tag,
    input  fft_word_t        i_data,
    output logic             o_valid,
    output logic [TAG_W-1:0] o_tag,
    output pwr_t             o_mag
);
    logic signed [27:0] w_re_x;
    logic signed [27:0] w_im_x;
    logic signed [27:0] w_re2;
    logic signed [27:0] w_im2;

    // Each square is at most 2^26, so the unsigned 28-bit sum cannot overflow.
    assign w_re_x = 28'(i_data.re);
    assign w_im_x = 28'(i_data.im);
    assign w_re2  = w_re_x * w_re_x;
    assign w_im2  = w_im_x * w_im_x;

    always_ff @(posedge clk) begin
        if (reset) begin
            o_valid <= 1'b0;
            o_tag   <= '0;
            o_mag   <= '0;
        end else begin
            o_valid <= i_valid;
            o_tag   <= i_tag;
            o_mag   <= pwr_t'(w_re2) + pwr_t'(w_im2);
        end
    end
endmodule

// File: rtl/freq_peak_detect.sv
// rtl/freq_peak_detect.sv - scans FFT RAM bins, finds the strongest bin and parks the read address on it
module freq_peak_detect
    import fft_pkg::*;
#(
    parameter int   ADDR_W   = FFT_ADDR_W,
    parameter int   LOW_BIN  = 1,
    parameter int   HIGH_BIN = 511,
    parameter int   RD_LAT   = 2,
    parameter pwr_t THRESH   = 28'd1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fftdone,
    input  logic [27:0]       ramq1,
    output logic [ADDR_W-1:0] rdaddr1,
    output logic [ADDR_W-1:0] maxbin,
    output pwr_t              maxpwr,
    output logic              detectdone,
    output logic              nodetect,
    output logic              busy,
    output logic              overrun
);
    localparam logic [ADDR_W-1:0] LOW_A  = ADDR_W'(LOW_BIN);
    localparam logic [ADDR_W-1:0] HIGH_A = ADDR_W'(HIGH_BIN);

    pd_state_t         r_state;
    pd_state_t         w_next;
    logic              w_start;
    logic              w_hit;
    logic [ADDR_W-1:0] r_addr;
    logic [RD_LAT-1:0] r_vpipe;
    logic [ADDR_W-1:0] r_tpipe [RD_LAT];
    pwr_t              r_runmax;
    logic [ADDR_W-1:0] r_runbin;
    logic              w_mag_valid;
    logic [ADDR_W-1:0] w_mag_tag;
    pwr_t              w_mag;

    mag_sq #(.TAG_W(ADDR_W)) u_mag_sq (
        .clk     (clk),
        .reset   (reset),
        .i_valid (r_vpipe[RD_LAT-1]),
        .i_tag   (r_tpipe[RD_LAT-1]),
        .i_data  (fft_word_t'(ramq1)),
        .o_valid (w_mag_valid),
        .o_tag   (w_mag_tag),
        .o_mag   (w_mag)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // DRAIN leaves once the read pipe is empty; the last mag_sq result lands in runmax during that same edge.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_hit   = 1'b0;
        busy    = 1'b0;
        rdaddr1 = maxbin;
        case (r_state)
            ST_IDLE: begin
                if (fftdone) begin
                    w_next  = ST_SCAN;
                    w_start = 1'b1;
                end
            end
            ST_SCAN: begin
                busy    = 1'b1;
                rdaddr1 = r_addr;
                if (r_addr == HIGH_A) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy    = 1'b1;
                rdaddr1 = HIGH_A;
                if (r_vpipe == '0) w_next = ST_FINISH;
            end
            ST_FINISH: begin
                w_hit   = (r_runmax >= THRESH);
                rdaddr1 = w_hit ? r_runbin : maxbin;
                w_next  = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr     <= '0;
            r_vpipe    <= '0;
            r_runmax   <= '0;
            r_runbin   <= '0;
            maxbin     <= '0;
            maxpwr     <= '0;
            detectdone <= 1'b0;
            nodetect   <= 1'b0;
            overrun    <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) r_tpipe[i] <= '0;
        end else begin
            detectdone <= 1'b0;
            nodetect   <= 1'b0;
            overrun    <= fftdone && (r_state != ST_IDLE);
            r_vpipe[0] <= (r_state == ST_SCAN);
            r_tpipe[0] <= r_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
                r_tpipe[i] <= r_tpipe[i-1];
            end
            if (w_start) begin
                r_addr   <= LOW_A;
                r_runmax <= '0;
                r_runbin <= LOW_A;
            end else begin
                if (r_state == ST_SCAN && r_addr != HIGH_A) r_addr <= r_addr + ADDR_W'(1);
                // Strict compare keeps the lowest bin on ties.
                if (w_mag_valid && w_mag > r_runmax) begin
                    r_runmax <= w_mag;
                    r_runbin <= w_mag_tag;
                end
            end
            if (r_state == ST_FINISH) begin
                if (w_hit) begin
                    maxbin     <= r_runbin;
                    maxpwr     <= r_runmax;
                    detectdone <= 1'b1;
                end else begin
                    nodetect   <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_freq_peak_detect.sv
// tb/tb_freq_peak_detect.sv - table-driven and randomized checks of freq_peak_detect against a spectral peak model
module tb_freq_peak_detect;
    localparam int LOW  = 1;
    localparam int HIGH = 511;
    localparam int NB   = HIGH - LOW + 1;
    localparam int LAT  = NB + 2 + 3;

    logic        clk;
    logic        reset;
    logic        fftdone;
    logic [27:0] ramq1;
    logic [9:0]  rdaddr1;
    logic [9:0]  maxbin;
    logic [27:0] maxpwr;
    logic        detectdone;
    logic        nodetect;
    logic        busy;
    logic        overrun;

    freq_peak_detect dut (
        .clk        (clk),
        .reset      (reset),
        .fftdone    (fftdone),
        .ramq1      (ramq1),
        .rdaddr1    (rdaddr1),
        .maxbin     (maxbin),
        .maxpwr     (maxpwr),
        .detectdone (detectdone),
        .nodetect   (nodetect),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [27:0] mem [1024];
    logic [27:0] ram_d1;
    always @(posedge clk) begin
        ram_d1 <= mem[rdaddr1];
        ramq1  <= ram_d1;
    end

    typedef struct {
        string  name;
        int     bg_re, bg_im;
        int     b1, re1, im1;
        int     b2, re2, im2;
        bit     exp_det;
        int     exp_bin;
        longint exp_pwr;
    } vec_t;
    vec_t vecs[4];

    int passed = 0;
    int total  = 0;
    int done_cyc, det_cnt, nod_cnt, ovr_cnt, ovr_cyc, busy_cnt;
    bit sweep_ok, zero_ok;
    int     exp_bin;
    longint exp_pwr;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    function automatic logic [27:0] pack(input int re, input int im);
        logic [13:0] r;
        logic [13:0] i;
        r = re[13:0];
        i = im[13:0];
        return {r, i};
    endfunction

    task automatic fill_bg(input int re, input int im);
        for (int b = 0; b < 1024; b++) mem[b] = pack(re, im);
    endtask

    // Reference: strongest bin over LOW..HIGH, starting from zero power at LOW, lowest bin wins ties.
    task automatic ref_peak(output int bin, output longint pwr);
        logic signed [13:0] re14;
        logic signed [13:0] im14;
        longint p;
        bin = LOW;
        pwr = 0;
        for (int b = LOW; b <= HIGH; b++) begin
            re14 = mem[b][27:14];
            im14 = mem[b][13:0];
            p = longint'(re14) * longint'(re14) + longint'(im14) * longint'(im14);
            if (p > pwr) begin
                pwr = p;
                bin = b;
            end
        end
    endtask

    task automatic run_frame(input int ovr_at, input int rst_at);
        done_cyc = -1; det_cnt = 0; nod_cnt = 0; ovr_cnt = 0; ovr_cyc = -1; busy_cnt = 0;
        sweep_ok = 1'b1; zero_ok = 1'b1;
        fftdone = 1'b1;
        step();
        fftdone = 1'b0;
        for (int k = 1; k <= 530; k++) begin
            if (k <= NB && (rst_at == 0 || k <= rst_at) && int'(rdaddr1) != LOW + k - 1) sweep_ok = 1'b0;
            if (rst_at != 0 && k == rst_at + 1 &&
                (rdaddr1 != 0 || maxbin != 0 || maxpwr != 0 || detectdone || nodetect || busy || overrun))
                zero_ok = 1'b0;
            if (busy) busy_cnt++;
            if (detectdone) begin det_cnt++; if (done_cyc < 0) done_cyc = k; end
            if (nodetect)   begin nod_cnt++; if (done_cyc < 0) done_cyc = k; end
            if (overrun)    begin ovr_cnt++; ovr_cyc = k; end
            if (k == ovr_at) fftdone = 1'b1;
            if (k == rst_at) reset = 1'b1;
            step();
            fftdone = 1'b0;
            reset   = 1'b0;
        end
    endtask

    task automatic verify_frame(input string tag, input bit det, input int bin, input longint pwr);
        check({tag, " done_cycle"}, done_cyc, LAT);
        check({tag, " detectdone_pulses"}, det_cnt, det ? 1 : 0);
        check({tag, " nodetect_pulses"}, nod_cnt, det ? 0 : 1);
        check({tag, " maxbin"}, maxbin, bin);
        check({tag, " maxpwr"}, maxpwr, pwr);
        check({tag, " rdaddr1_parked"}, rdaddr1, bin);
        check({tag, " addr_sweep"}, sweep_ok, 1);
        check({tag, " busy_cycles"}, busy_cnt, NB + 3);
    endtask

    initial begin
        int     rb;
        longint rp;
        int     mode, v_re, v_im, b;

        vecs[0] = '{"tone",    3, 4,  37,  1000,  -500,  -1,     0,     0, 1'b1,  37,   1250000};
        vecs[1] = '{"silence", 0, 0,  -1,     0,     0,  -1,     0,     0, 1'b0,  37,   1250000};
        vecs[2] = '{"tie",     3, 4, 100, -8192, -8192, 200, -8192, -8192, 1'b1, 100, 134217728};
        vecs[3] = '{"edge",    0, 0,   0,  5000,  5000, 511,  2000,     0, 1'b1, 511,   4000000};

        reset = 1'b1;
        fftdone = 1'b0;
        fill_bg(0, 0);
        repeat (3) step();
        check("reset rdaddr1", rdaddr1, 0);
        check("reset maxbin", maxbin, 0);
        check("reset maxpwr", maxpwr, 0);
        check("reset pulses_busy", {detectdone, nodetect, busy, overrun}, 0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 4; i++) begin
            fill_bg(vecs[i].bg_re, vecs[i].bg_im);
            if (vecs[i].b1 >= 0) mem[vecs[i].b1] = pack(vecs[i].re1, vecs[i].im1);
            if (vecs[i].b2 >= 0) mem[vecs[i].b2] = pack(vecs[i].re2, vecs[i].im2);
            run_frame(0, 0);
            verify_frame(vecs[i].name, vecs[i].exp_det, vecs[i].exp_bin, vecs[i].exp_pwr);
            check({vecs[i].name, " overrun_pulses"}, ovr_cnt, 0);
            step();
        end

        fill_bg(3, 4);
        mem[37] = pack(1000, -500);
        run_frame(100, 0);
        verify_frame("overrun", 1'b1, 37, 1250000);
        check("overrun pulse_cycle", ovr_cyc, 101);
        check("overrun pulse_count", ovr_cnt, 1);
        check("overrun no_restart_busy", busy, 0);

        run_frame(0, 300);
        check("midreset outputs_zero", zero_ok, 1);
        check("midreset no_pulses", det_cnt + nod_cnt, 0);
        check("midreset busy_cycles", busy_cnt, 300);
        check("midreset maxbin", maxbin, 0);
        run_frame(0, 0);
        verify_frame("after_reset", 1'b1, 37, 1250000);
        exp_bin = 37;
        exp_pwr = 1250000;

        for (int r = 0; r < 6; r++) begin
            mode = r % 3;
            for (int k = 0; k < 1024; k++) begin
                if (mode == 0) begin
                    v_re = int'($urandom_range(16383)) - 8192;
                    v_im = int'($urandom_range(16383)) - 8192;
                end else if (mode == 1) begin
                    v_re = int'($urandom_range(4)) - 2;
                    v_im = int'($urandom_range(4)) - 2;
                end else begin
                    v_re = 0;
                    v_im = 0;
                end
                mem[k] = pack(v_re, v_im);
            end
            if (mode == 2 && r != 2) begin
                v_re = int'($urandom_range(16383)) - 8192;
                v_im = int'($urandom_range(200)) - 100;
                for (int j = 0; j < 2; j++) begin
                    b = int'($urandom_range(511));
                    mem[b] = pack(v_re, v_im);
                end
            end
            ref_peak(rb, rp);
            if (rp >= 1) begin
                exp_bin = rb;
                exp_pwr = rp;
            end
            run_frame(0, 0);
            verify_frame($sformatf("random%0d", r), rp >= 1, exp_bin, exp_pwr);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
